// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, default
// geometry and the fetch timer width helper.
package instr_fetch_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } fetch_state_e;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 255;

  // A disabled timeout (0) still gets a 1-bit counter so the port stays legal.
  function automatic int timer_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory request/response channel and instruction-register channel between
// the fetch unit (master) and memory plus decode/execute (slave).
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; once raised, valid and its payload hold until that transfer.
  // mem_rsp_valid has no ready: it is only meaningful while a read is open.
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              ir_valid;
  logic              ir_ready;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_pc;

  modport master (
    output mem_req_valid, mem_req_addr, ir_valid, ir_data, ir_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, ir_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, ir_valid, ir_data, ir_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, ir_ready
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_timer.sv
// Response watchdog counter: clear, count-enable and a terminal flag that
// fires in the cycle the count is about to reach LIMIT.
module fetch_timer #(
  parameter int LIMIT = 255,
  parameter int W     = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic en,
  output logic done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign done = en && (count == W'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Non-pipelined instruction fetch sequencer: requests the word at pc, holds it
// in the instruction register until retired, then strobes pc_enb.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_enb,
  input  logic              halt,
  output logic              halted,
  output logic              fetch_fault,
  output fetch_state_e      state,
  instr_fetch_unit_if.master bus
);

  localparam int TW = timer_width(TIMEOUT);

  logic              req_valid;
  logic              ir_valid;
  logic              halted_q;
  logic              fault_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] ir_data_q;
  logic [ADDR_W-1:0] ir_pc_q;
  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_done;
  logic              timeout_hit;

  assign tmr_clear   = (state == S_REQ) && bus.mem_req_ready;
  assign tmr_en      = (state == S_WAIT);
  assign timeout_hit = (TIMEOUT != 0) && tmr_done;

  fetch_timer #(
    .LIMIT (TIMEOUT),
    .W     (TW)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .done   (tmr_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      req_valid <= 1'b0;
      ir_valid  <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      addr_q    <= '0;
      ir_data_q <= '0;
      ir_pc_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!halt) begin
            state     <= S_REQ;
            req_valid <= 1'b1;
            halted_q  <= 1'b0;
          end else begin
            halted_q  <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            state     <= S_WAIT;
            req_valid <= 1'b0;
            addr_q    <= pc;
          end
        end
        S_WAIT: begin
          // A response in the terminal cycle still wins over the timeout.
          if (bus.mem_rsp_valid) begin
            state     <= S_HOLD;
            ir_valid  <= 1'b1;
            ir_data_q <= bus.mem_rsp_data;
            ir_pc_q   <= addr_q;
          end else if (timeout_hit) begin
            state     <= S_FAULT;
            fault_q   <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.ir_ready) begin
            ir_valid <= 1'b0;
            if (halt) begin
              state    <= S_IDLE;
              halted_q <= 1'b1;
            end else begin
              state     <= S_REQ;
              req_valid <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state     <= S_IDLE;
          req_valid <= 1'b0;
          ir_valid  <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  // pc is only advanced by pc_enb, so driving it straight out keeps the
  // request address stable for the whole REQ phase.
  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = req_valid ? pc : addr_q;
  assign bus.ir_valid      = ir_valid;
  assign bus.ir_data       = ir_data_q;
  assign bus.ir_pc         = ir_pc_q;
  assign pc_enb            = ir_valid & bus.ir_ready;
  assign halted            = halted_q;
  assign fetch_fault       = fault_q;

endmodule
